// File: rtl/core_pkg.sv
// Shared types for the 5-stage core: register address width, forwarding
// select encodings and the per-stage destination metadata slot.
package core_pkg;

   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic                  mem_to_reg;
      logic [REG_ADDR_W-1:0] dest;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
   } slot_t;

   // A slot produces register r; r0 is hardwired zero and never produced.
   function automatic logic slot_writes(input slot_t s, input logic [REG_ADDR_W-1:0] r);
      return s.valid && s.reg_write && (s.dest == r) && (r != '0);
   endfunction

endpackage

// File: rtl/stage_slot_reg.sv
// One pipeline-stage metadata register; hold wins over bubble, bubble over load.
module stage_slot_reg
   import core_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  hold_i,
   input  logic  bubble_i,
   input  slot_t load_i,
   output slot_t slot_o
);

   slot_t slot_q, slot_d;

   always_comb begin
      slot_d = load_i;
      if (hold_i) begin
         slot_d = slot_q;
      end else if (bubble_i) begin
         slot_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot_o = slot_q;

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller for the F/D/E/M/W core: stalls, flushes, forwarding selects
// and a saturating stall-cycle counter, driven from shadow E/M/W slots.
module hazard_controller
   import core_pkg::*;
#(
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   valid_d,
   input  logic [REG_ADDR_W-1:0]  rs_d,
   input  logic [REG_ADDR_W-1:0]  rt_d,
   input  logic                   uses_rt_d,
   input  logic [REG_ADDR_W-1:0]  write_reg_d,
   input  logic                   reg_write_d,
   input  logic                   mem_to_reg_d,
   input  logic                   jump_d,
   input  logic                   branch_taken_e,
   input  logic                   mem_busy_m,
   output logic                   stall_f,
   output logic                   stall_d,
   output logic                   stall_e,
   output logic                   stall_m,
   output logic                   flush_d,
   output logic                   flush_e,
   output logic                   flush_w,
   output logic [1:0]             fwd_a_e,
   output logic [1:0]             fwd_b_e,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   slot_t e_q, m_q, w_q;
   slot_t d_slot, m_load;
   logic  load_use, busy, br_taken, lu_stall, jmp_flush;
   logic  [STALL_CNT_W-1:0] cnt_q, cnt_d;
   logic  unused_slot_bits;

   always_comb begin
      d_slot = '{valid: valid_d, reg_write: reg_write_d, mem_to_reg: mem_to_reg_d,
                 dest: write_reg_d, rs: rs_d, rt: rt_d};
      m_load    = e_q;
      m_load.rs = '0;
      m_load.rt = '0;
   end

   // Hazard classification in priority order: memory wait, taken branch, load-use, jump.
   always_comb begin
      load_use  = valid_d && e_q.mem_to_reg &&
                  (slot_writes(e_q, rs_d) || (uses_rt_d && slot_writes(e_q, rt_d)));
      busy      = !reset && mem_busy_m;
      br_taken  = !reset && !mem_busy_m && branch_taken_e;
      lu_stall  = !reset && !mem_busy_m && !branch_taken_e && load_use;
      jmp_flush = !reset && !mem_busy_m && !branch_taken_e && !load_use && jump_d && valid_d;
   end

   always_comb begin
      stall_f = busy || lu_stall;
      stall_d = busy || lu_stall;
      stall_e = busy;
      stall_m = busy;
      flush_d = br_taken || jmp_flush;
      flush_e = br_taken || lu_stall;
      flush_w = busy;
   end

   always_comb begin
      fwd_a_e = FWD_RF;
      fwd_b_e = FWD_RF;
      if (slot_writes(m_q, e_q.rs)) begin
         fwd_a_e = FWD_M;
      end else if (slot_writes(w_q, e_q.rs)) begin
         fwd_a_e = FWD_W;
      end
      if (slot_writes(m_q, e_q.rt)) begin
         fwd_b_e = FWD_M;
      end else if (slot_writes(w_q, e_q.rt)) begin
         fwd_b_e = FWD_W;
      end
   end

   stage_slot_reg u_slot_e (
      .clk      (clk),
      .rst      (reset),
      .hold_i   (busy),
      .bubble_i (br_taken || lu_stall),
      .load_i   (d_slot),
      .slot_o   (e_q)
   );

   stage_slot_reg u_slot_m (
      .clk      (clk),
      .rst      (reset),
      .hold_i   (busy),
      .bubble_i (1'b0),
      .load_i   (m_load),
      .slot_o   (m_q)
   );

   stage_slot_reg u_slot_w (
      .clk      (clk),
      .rst      (reset),
      .hold_i   (1'b0),
      .bubble_i (busy),
      .load_i   (m_q),
      .slot_o   (w_q)
   );

   // Stall-cycle counter sticks at all ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (stall_d && (cnt_q != '1)) begin
         cnt_d = cnt_q + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stall_cycles     = cnt_q;
   assign unused_slot_bits = ^{w_q.mem_to_reg, w_q.rs, w_q.rt};

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding, load-use, branch, memory wait,
// jump, asynchronous reset and counter saturation.
module tb_hazard_controller;

   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          valid_d, uses_rt_d, reg_write_d, mem_to_reg_d, jump_d;
   logic [4:0]    rs_d, rt_d, write_reg_d;
   logic          branch_taken_e, mem_busy_m;
   logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
   logic [1:0]    fwd_a_e, fwd_b_e;
   logic [CW-1:0] stall_cycles;

   int n_assert = 0;
   int n_fail   = 0;

   hazard_controller #(.STALL_CNT_W(CW)) dut (
      .clk            (clk),
      .reset          (reset),
      .valid_d        (valid_d),
      .rs_d           (rs_d),
      .rt_d           (rt_d),
      .uses_rt_d      (uses_rt_d),
      .write_reg_d    (write_reg_d),
      .reg_write_d    (reg_write_d),
      .mem_to_reg_d   (mem_to_reg_d),
      .jump_d         (jump_d),
      .branch_taken_e (branch_taken_e),
      .mem_busy_m     (mem_busy_m),
      .stall_f        (stall_f),
      .stall_d        (stall_d),
      .stall_e        (stall_e),
      .stall_m        (stall_m),
      .flush_d        (flush_d),
      .flush_e        (flush_e),
      .flush_w        (flush_w),
      .fwd_a_e        (fwd_a_e),
      .fwd_b_e        (fwd_b_e),
      .stall_cycles   (stall_cycles)
   );

   always #5 clk = ~clk;

   // ctl bit order: stall_f stall_d stall_e stall_m flush_d flush_e flush_w
   task automatic chk_ctl(input string tag, input logic [6:0] ctl,
                          input logic [1:0] a, input logic [1:0] b);
      logic [10:0] obs, exp;
      obs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, fwd_a_e, fwd_b_e};
      exp = {ctl, a, b};
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [CW-1:0] exp);
      n_assert++;
      assert (stall_cycles === exp) else begin
         n_fail++;
         $display("FAIL %s: observed stall_cycles %0h expected %0h", tag, stall_cycles, exp);
      end
   endtask

   task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic [4:0] wr, input logic rw,
                        input logic m2r, input logic jmp);
      valid_d      = v;
      rs_d         = rs;
      rt_d         = rt;
      uses_rt_d    = urt;
      write_reg_d  = wr;
      reg_write_d  = rw;
      mem_to_reg_d = m2r;
      jump_d       = jmp;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset          = 1'b1;
      branch_taken_e = 1'b1;
      mem_busy_m     = 1'b1;
      set_d(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
      #3;
      chk_ctl("reset_outputs", 7'b0000000, 2'b00, 2'b00);
      chk_cnt("reset_cnt", 16'h0000);
      branch_taken_e = 1'b0;
      mem_busy_m     = 1'b0;
      set_d(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      #1 chk_ctl("idle", 7'b0000000, 2'b00, 2'b00);

      // add r3 <- r1,r2 ; sub r6 <- r3,r4 ; or r7 <- r3 ; and r0 <- r6,r3 ; xor r8 <- r0,r0
      set_d(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); tick();
      set_d(1'b1, 5'd3, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); tick();
      set_d(1'b1, 5'd3, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      #1 chk_ctl("fwd_a_from_m", 7'b0000000, 2'b10, 2'b00);
      tick();
      set_d(1'b1, 5'd6, 5'd3, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
      #1 chk_ctl("fwd_a_from_w", 7'b0000000, 2'b01, 2'b00);
      tick();
      set_d(1'b1, 5'd0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
      #1 chk_ctl("fwd_w_only_a", 7'b0000000, 2'b01, 2'b00);
      tick();
      set_d(1'b1, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
      #1 chk_ctl("fwd_r0_never", 7'b0000000, 2'b00, 2'b00);
      tick();
      set_d(1'b1, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); tick();
      set_d(1'b1, 5'd9, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0); tick();

      // M and W both produce r9: M wins on both operands
      set_d(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      #1 chk_ctl("fwd_m_priority", 7'b0000000, 2'b10, 2'b10);
      tick();

      // lw r5 in E, D reads rt=r5
      set_d(1'b1, 5'd2, 5'd5, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
      #1 chk_ctl("load_use_stall", 7'b1100010, 2'b00, 2'b00);
      chk_cnt("load_use_cnt_before", 16'h0000);
      tick();
      #1 chk_ctl("load_use_one_cycle", 7'b0000000, 2'b00, 2'b00);
      chk_cnt("load_use_cnt_after", 16'h0001);
      tick();
      set_d(1'b1, 5'd1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
      #1 chk_ctl("load_use_fwd_b", 7'b0000000, 2'b00, 2'b01);
      tick();

      // taken branch while a load-use condition is also present
      set_d(1'b1, 5'd12, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
      branch_taken_e = 1'b1;
      #1 chk_ctl("branch_over_load_use", 7'b0000110, 2'b00, 2'b00);
      tick();
      branch_taken_e = 1'b0;
      #1 chk_cnt("branch_cnt_unchanged", 16'h0001);

      // beq into E, then memory wait for 3 cycles with the branch taken
      set_d(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); tick();
      set_d(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      branch_taken_e = 1'b1;
      mem_busy_m     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk_ctl($sformatf("mem_wait_%0d", i), 7'b1111001, 2'b00, 2'b00);
         tick();
      end
      mem_busy_m = 1'b0;
      #1 chk_ctl("branch_after_wait", 7'b0000110, 2'b00, 2'b00);
      chk_cnt("mem_wait_cnt", 16'h0004);
      tick();
      branch_taken_e = 1'b0;

      // plain jump
      set_d(1'b1, 5'd4, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b1);
      #1 chk_ctl("jump_only_flush_d", 7'b0000100, 2'b00, 2'b00);
      tick();

      // asynchronous reset in the middle of a load-use stall
      set_d(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); tick();
      set_d(1'b1, 5'd5, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
      #1 chk_ctl("pre_reset_stall", 7'b1100010, 2'b00, 2'b00);
      reset = 1'b1;
      #1 chk_ctl("reset_mid_stall", 7'b0000000, 2'b00, 2'b00);
      chk_cnt("reset_mid_cnt", 16'h0000);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 chk_ctl("slots_invalid_after_reset", 7'b0000000, 2'b00, 2'b00);

      // 2^16 + 5 stalled edges: counter must stop at all ones
      set_d(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      mem_busy_m = 1'b1;
      repeat (65534) tick();
      chk_cnt("cnt_near_max", 16'hFFFE);
      repeat (7) tick();
      chk_cnt("cnt_saturated", 16'hFFFF);
      chk_ctl("still_waiting", 7'b1111001, 2'b00, 2'b00);
      mem_busy_m = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
